// File: rtl/microsequencer_if.sv
// microsequencer_if: bundle between the microsequencer, its microcode ROM and
// the datapath. The sequencer side uses the master modport.
//
// Handshake: a microword with wait=1 starts a memory access and completes on
// the first rising edge where mem_ready=1. In every cycle where wait=1 and
// mem_ready=0, stall is high, the sequencer holds all of its state, and the
// datapath must ignore ctrl (it qualifies its writes with ~stall).
`timescale 1ns/1ps
interface microsequencer_if #(
  parameter int OPCODE_W   = 8,
  parameter int UADDR_W    = 6,
  parameter int CTRL_W     = 20,
  parameter int FLAG_SEL_W = 2
);
  localparam int FLAG_W  = 2 ** FLAG_SEL_W;
  localparam int UWORD_W = CTRL_W + UADDR_W + FLAG_SEL_W + 5;

  logic [OPCODE_W-1:0] opcode;
  logic [FLAG_W-1:0]   flags;
  logic                mem_ready;
  logic [UWORD_W-1:0]  uword;
  logic [UADDR_W-1:0]  uaddr;
  logic [CTRL_W-1:0]   ctrl;
  logic                stall;
  logic                instr_done;
  logic                uerr;

  modport master (
    input  opcode, flags, mem_ready, uword,
    output uaddr, ctrl, stall, instr_done, uerr
  );

  modport slave (
    output opcode, flags, mem_ready, uword,
    input  uaddr, ctrl, stall, instr_done, uerr
  );
endinterface

// File: rtl/microsequencer.sv
// microsequencer: micro-PC sequencer for the microcoded accumulator CPU.
// Drives a combinational microcode ROM address and forwards the ROM control
// field. Supports NEXT/JUMP/DISPATCH/CBRANCH/CALL/RET/END and memory stalls.
// Optional feature macro: MICROSEQ_STACK_EN enables the microsubroutine
// return stack (CALL/RET and the sticky uerr flag). Without it CALL acts as
// JUMP, RET returns to word 0 without instr_done, and uerr is 0.
// The uPC itself is the sequencer state and is always visible on uaddr.
`timescale 1ns/1ps
module microsequencer #(
  parameter int OPCODE_W    = 8,
  parameter int UADDR_W     = 6,
  parameter int CTRL_W      = 20,
  parameter int FLAG_SEL_W  = 2,
  parameter int STACK_DEPTH = 2
) (
  input logic              clk,
  input logic              res,
  microsequencer_if.master bus
);
  localparam int TGT_LSB  = CTRL_W;
  localparam int SEL_LSB  = TGT_LSB + UADDR_W;
  localparam int POL_BIT  = SEL_LSB + FLAG_SEL_W;
  localparam int WAIT_BIT = POL_BIT + 1;
  localparam int SEQ_LSB  = WAIT_BIT + 1;

  localparam logic [2:0] SEQ_NEXT     = 3'd0;
  localparam logic [2:0] SEQ_JUMP     = 3'd1;
  localparam logic [2:0] SEQ_DISPATCH = 3'd2;
  localparam logic [2:0] SEQ_CBRANCH  = 3'd3;
  localparam logic [2:0] SEQ_CALL     = 3'd4;
  localparam logic [2:0] SEQ_RET      = 3'd5;
  localparam logic [2:0] SEQ_END      = 3'd6;

  if (STACK_DEPTH < 1) begin : g_depth_check
    $error("microsequencer: STACK_DEPTH must be at least 1");
  end

  logic [CTRL_W-1:0]     f_ctrl;
  logic [UADDR_W-1:0]    f_target;
  logic [FLAG_SEL_W-1:0] f_cond_sel;
  logic                  f_cond_pol;
  logic                  f_wait;
  logic [2:0]            f_seq;

  assign f_ctrl     = bus.uword[CTRL_W-1:0];
  assign f_target   = bus.uword[TGT_LSB +: UADDR_W];
  assign f_cond_sel = bus.uword[SEL_LSB +: FLAG_SEL_W];
  assign f_cond_pol = bus.uword[POL_BIT];
  assign f_wait     = bus.uword[WAIT_BIT];
  assign f_seq      = bus.uword[SEQ_LSB +: 3];

  logic [UADDR_W-1:0] upc;
  logic [UADDR_W-1:0] upc_inc;
  logic [UADDR_W-1:0] upc_disp;
  logic [UADDR_W-1:0] upc_nxt;
  logic               stall_int;
  logic               cond_hit;
  logic               is_end;

  // All uPC arithmetic wraps modulo the microprogram depth.
  assign upc_inc   = upc + UADDR_W'(1);
  assign upc_disp  = f_target + UADDR_W'(bus.opcode);
  assign cond_hit  = (bus.flags[f_cond_sel] == f_cond_pol);
  assign stall_int = f_wait & ~bus.mem_ready;

`ifdef MICROSEQ_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0]    sp;
  logic [UADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   top_idx;
  logic               stack_full;
  logic               stack_empty;
  logic               do_push;
  logic               do_pop;
  logic               err_set;
  logic               uerr_q;

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign push_idx    = IDX_W'(sp);
  assign top_idx     = IDX_W'(sp - SP_W'(1));
`endif

  // Next-uPC selection and stack/error side effects for the current microword.
  always_comb begin
    upc_nxt = upc_inc;
    is_end  = 1'b0;
`ifdef MICROSEQ_STACK_EN
    do_push = 1'b0;
    do_pop  = 1'b0;
    err_set = 1'b0;
`endif
    case (f_seq)
      SEQ_JUMP:     upc_nxt = f_target;
      SEQ_DISPATCH: upc_nxt = upc_disp;
      SEQ_CBRANCH:  if (cond_hit) upc_nxt = f_target;
      SEQ_CALL: begin
        // Overflow drops the return address but still takes the jump.
        upc_nxt = f_target;
`ifdef MICROSEQ_STACK_EN
        if (stack_full) err_set = 1'b1;
        else            do_push = 1'b1;
`endif
      end
      SEQ_RET: begin
`ifdef MICROSEQ_STACK_EN
        if (stack_empty) begin
          upc_nxt = '0;
          err_set = 1'b1;
        end else begin
          upc_nxt = stack_mem[top_idx];
          do_pop  = 1'b1;
        end
`else
        upc_nxt = '0;
`endif
      end
      SEQ_END: begin
        upc_nxt = '0;
        is_end  = 1'b1;
      end
      default: upc_nxt = upc_inc;
    endcase
  end

  // uPC register: advances once per unstalled cycle.
  always_ff @(posedge clk or negedge res) begin
    if (!res)            upc <= '0;
    else if (!stall_int) upc <= upc_nxt;
  end

`ifdef MICROSEQ_STACK_EN
  // Return stack, stack pointer and sticky error; all frozen while stalled.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sp     <= '0;
      uerr_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
    end else if (!stall_int) begin
      if (do_push) begin
        stack_mem[push_idx] <= upc_inc;
        sp                  <= sp + SP_W'(1);
      end
      if (do_pop)  sp     <= sp - SP_W'(1);
      if (err_set) uerr_q <= 1'b1;
    end
  end

  assign bus.uerr = uerr_q;
`else
  assign bus.uerr = 1'b0;
`endif

  assign bus.uaddr      = upc;
  assign bus.ctrl       = res ? f_ctrl : '0;
  assign bus.stall      = stall_int;
  assign bus.instr_done = res & ~stall_int & is_end;
endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer: directed and randomized checks of the microsequencer
// against a queue/array reference model of the microprogram rules.
`timescale 1ns/1ps
module tb_microsequencer;
  localparam int OPCODE_W    = 8;
  localparam int UADDR_W     = 6;
  localparam int CTRL_W      = 20;
  localparam int FLAG_SEL_W  = 2;
  localparam int STACK_DEPTH = 2;
  localparam int FLAG_W      = 2 ** FLAG_SEL_W;
  localparam int UWORD_W     = CTRL_W + UADDR_W + FLAG_SEL_W + 5;
  localparam int DEPTH       = 2 ** UADDR_W;
  localparam int EXP_W       = UADDR_W + CTRL_W + 3;
  localparam int TGT_LSB     = CTRL_W;
  localparam int SEL_LSB     = TGT_LSB + UADDR_W;
  localparam int POL_BIT     = SEL_LSB + FLAG_SEL_W;
  localparam int WAIT_BIT    = POL_BIT + 1;
  localparam int SEQ_LSB     = WAIT_BIT + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  microsequencer_if #(
    .OPCODE_W(OPCODE_W), .UADDR_W(UADDR_W), .CTRL_W(CTRL_W), .FLAG_SEL_W(FLAG_SEL_W)
  ) bus ();

  microsequencer #(
    .OPCODE_W(OPCODE_W), .UADDR_W(UADDR_W), .CTRL_W(CTRL_W),
    .FLAG_SEL_W(FLAG_SEL_W), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus.master)
  );

  // Combinational microcode ROM owned by the bench.
  logic [UWORD_W-1:0] rom [DEPTH];
  assign bus.uword = rom[bus.uaddr];

  // ---------------- reference model state ----------------
  int m_upc;
  int m_stk[$];
  bit m_uerr;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [UWORD_W-1:0] mk(input int seq, input int wt, input int pol,
                                            input int sel, input int tgt,
                                            input logic [CTRL_W-1:0] c);
    logic [UWORD_W-1:0] w;
    w = '0;
    w[CTRL_W-1:0]              = c;
    w[TGT_LSB +: UADDR_W]      = tgt[UADDR_W-1:0];
    w[SEL_LSB +: FLAG_SEL_W]   = sel[FLAG_SEL_W-1:0];
    w[POL_BIT]                 = pol[0];
    w[WAIT_BIT]                = wt[0];
    w[SEQ_LSB +: 3]            = seq[2:0];
    return w;
  endfunction

  function automatic logic [UWORD_W-1:0] rand_word();
    return mk(int'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0) ? 1 : 0,
              int'($urandom_range(0, 1)), int'($urandom_range(0, FLAG_W - 1)),
              int'($urandom_range(0, DEPTH - 1)), CTRL_W'($urandom));
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = mk(0, 0, 0, 0, 0, CTRL_W'(i * 3 + 1));
  endtask

  // Outputs the model predicts for the current cycle.
  function automatic logic [EXP_W-1:0] model_out();
    logic [UWORD_W-1:0] w;
    logic [CTRL_W-1:0]  c;
    logic               stl;
    logic               done;
    w    = rom[m_upc];
    stl  = w[WAIT_BIT] && !bus.mem_ready;
    c    = res ? w[CTRL_W-1:0] : '0;
    done = res && !stl && (w[SEQ_LSB +: 3] == 3'd6);
    return {UADDR_W'(m_upc), c, stl, done, m_uerr};
  endfunction

  // Applies one rising edge of the microprogram rules to the model.
  task automatic model_edge();
    logic [UWORD_W-1:0] w;
    int seq, tgt, sel, nxt;
    bit pol;
    w   = rom[m_upc];
    seq = int'(w[SEQ_LSB +: 3]);
    tgt = int'(w[TGT_LSB +: UADDR_W]);
    sel = int'(w[SEL_LSB +: FLAG_SEL_W]);
    pol = w[POL_BIT];
    if (w[WAIT_BIT] && !bus.mem_ready) return;
    nxt = (m_upc + 1) % DEPTH;
    case (seq)
      1: nxt = tgt;
      2: nxt = (tgt + int'(bus.opcode)) % DEPTH;
      3: if (bus.flags[sel] == pol) nxt = tgt;
      4: begin
`ifdef MICROSEQ_STACK_EN
        if (m_stk.size() >= STACK_DEPTH) m_uerr = 1'b1;
        else m_stk.push_back((m_upc + 1) % DEPTH);
`endif
        nxt = tgt;
      end
      5: begin
`ifdef MICROSEQ_STACK_EN
        if (m_stk.size() == 0) begin
          nxt = 0;
          m_uerr = 1'b1;
        end else begin
          nxt = m_stk.pop_back();
        end
`else
        nxt = 0;
`endif
      end
      6: nxt = 0;
      default: ;
    endcase
    m_upc = nxt;
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge with inputs already set for this cycle.
  task automatic step();
    exp_q.push_back(model_out());
    @(posedge clk);
    if (res) model_edge();
    #1;
  endtask

  task automatic do_reset();
    res = 1'b0;
    m_upc = 0;
    m_stk.delete();
    m_uerr = 1'b0;
    step();
    step();
    res = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] a;
      e = exp_q.pop_front();
      a = {bus.uaddr, bus.ctrl, bus.stall, bus.instr_done, bus.uerr};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs @%0t: uaddr %h/%h ctrl %h/%h stall %b/%b done %b/%b uerr %b/%b (got/expected)",
                 $time, a[EXP_W-1 -: UADDR_W], e[EXP_W-1 -: UADDR_W],
                 a[3 +: CTRL_W], e[3 +: CTRL_W], a[2], e[2], a[1], e[1], a[0], e[0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.opcode    = '0;
    bus.flags     = '0;
    bus.mem_ready = 1'b1;
    m_upc  = 0;
    m_uerr = 1'b0;
    clear_rom();
    @(posedge clk);
    #1;

    // Reset holds ctrl at 0; release exposes word 0, first edge dispatches.
    rom[0]    = mk(2, 0, 0, 0, 'h10, 20'h12345);
    rom['h13] = mk(1, 0, 0, 0, 0, 20'h00013);
    bus.opcode = 8'h03;
    step();
    check("rst_ctrl", 32'(bus.ctrl), 32'h0);
    check("rst_uaddr", 32'(bus.uaddr), 32'h0);
    check("rst_done", 32'(bus.instr_done), 32'h0);
    res = 1'b1;
    #1;
    check("rel_ctrl", 32'(bus.ctrl), 32'h12345);
    step();
    check("dispatch", 32'(bus.uaddr), 32'h13);

    // Dispatch wrap, then uPC+1 wrap at all-ones.
    clear_rom();
    rom[0]    = mk(2, 0, 0, 0, 'h3E, 20'h00abc);
    rom[3]    = mk(1, 0, 0, 0, 'h3F, 20'h00003);
    bus.opcode = 8'h05;
    do_reset();
    step();
    check("dispatch_wrap", 32'(bus.uaddr), 32'h03);
    step();
    step();
    check("next_wrap", 32'(bus.uaddr), 32'h00);

    // Conditional branch taken and not taken.
    clear_rom();
    rom[0] = mk(3, 0, 1, 1, 'h20, 20'h00c0b);
    bus.flags = 4'b0010;
    do_reset();
    step();
    check("cbr_taken", 32'(bus.uaddr), 32'h20);
    bus.flags = 4'b0000;
    do_reset();
    step();
    check("cbr_not_taken", 32'(bus.uaddr), 32'h01);

    // END with a wait state.
    clear_rom();
    rom[0] = mk(1, 0, 0, 0, 5, 20'h00001);
    rom[5] = mk(6, 1, 0, 0, 0, 20'h00555);
    do_reset();
    step();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_uaddr", 32'(bus.uaddr), 32'h05);
      check("stall_flag", 32'(bus.stall), 32'h1);
      check("stall_done", 32'(bus.instr_done), 32'h0);
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("end_done", 32'(bus.instr_done), 32'h1);
    step();
    check("end_uaddr", 32'(bus.uaddr), 32'h00);
    check("end_done_pulse", 32'(bus.instr_done), 32'h0);

`ifdef MICROSEQ_STACK_EN
    // Nested calls, returns, overflow.
    clear_rom();
    rom[0]  = mk(1, 0, 0, 0, 5, 20'h0);
    rom[5]  = mk(4, 0, 0, 0, 8, 20'h5);
    rom[8]  = mk(4, 0, 0, 0, 12, 20'h8);
    rom[12] = mk(5, 0, 0, 0, 0, 20'hc);
    rom[9]  = mk(5, 0, 0, 0, 0, 20'h9);
    rom[6]  = mk(4, 0, 0, 0, 16, 20'h6);
    rom[16] = mk(4, 0, 0, 0, 24, 20'h10);
    rom[24] = mk(4, 0, 0, 0, 32, 20'h18);
    rom[32] = mk(1, 0, 0, 0, 32, 20'h20);
    do_reset();
    step();
    step(); check("call1", 32'(bus.uaddr), 32'd8);
    step(); check("call2", 32'(bus.uaddr), 32'd12);
    step(); check("ret1", 32'(bus.uaddr), 32'd9);
    step(); check("ret2", 32'(bus.uaddr), 32'd6);
    check("ret_uerr", 32'(bus.uerr), 32'h0);
    step();
    step();
    step(); check("ovf_uaddr", 32'(bus.uaddr), 32'd32);
    check("ovf_uerr", 32'(bus.uerr), 32'h1);
    clear_rom();
    rom[0] = mk(5, 0, 0, 0, 9, 20'h7);
    do_reset();
    step(); check("unf_uaddr", 32'(bus.uaddr), 32'h0);
    check("unf_uerr", 32'(bus.uerr), 32'h1);
`else
    // Without the stack: CALL jumps, RET goes to 0 silently.
    clear_rom();
    rom[0] = mk(1, 0, 0, 0, 5, 20'h0);
    rom[5] = mk(4, 0, 0, 0, 8, 20'h5);
    rom[8] = mk(5, 0, 0, 0, 0, 20'h8);
    do_reset();
    step();
    step(); check("nostk_call", 32'(bus.uaddr), 32'd8);
    check("nostk_ret_done", 32'(bus.instr_done), 32'h0);
    step(); check("nostk_ret", 32'(bus.uaddr), 32'h0);
    check("nostk_uerr", 32'(bus.uerr), 32'h0);
`endif

    // Randomized microprograms and inputs, with occasional mid-run resets.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
      do_reset();
      for (int c = 0; c < 500; c++) begin
        bus.opcode    = OPCODE_W'($urandom);
        bus.flags     = FLAG_W'($urandom);
        bus.mem_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 199) == 0) do_reset();
        else step();
      end
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/microsequencer.md
# microsequencer

Parametrised microprogram sequencer for the microcoded accumulator CPU and the successor to the fixed controller unit. It generalises the control-word width, microprogram depth, opcode width and flag count. It adds opcode dispatch, conditional microbranches on ALU flags, a microsubroutine stack and memory wait-state stalling. The block holds the micro-PC (uPC), drives the address of an external combinational microcode ROM, and forwards the ROM's control field to the datapath (AC/MAR/MDR/PC/IR write enables and sources, ALU select).

## Interface
Parameters:
- OPCODE_W, 8, opcode width from IR
- UADDR_W, 6, microaddress width (microprogram depth 2**UADDR_W)
- CTRL_W, 20, datapath control field width
- FLAG_SEL_W, 2, flag selector width; flag count FLAG_W = 2**FLAG_SEL_W
- STACK_DEPTH, 2, microsubroutine return-stack entries (>=1)

Derived: UWORD_W = CTRL_W + UADDR_W + FLAG_SEL_W + 5.

Ports:
- clk  in  1  system clock, rising edge
- res  in  1  reset, asynchronous, active-low
- opcode  in  OPCODE_W  current IR contents
- flags  in  FLAG_W  ALU flag register
- mem_ready  in  1  memory access complete
- uword  in  UWORD_W  microword read from ROM at uaddr (combinational ROM)
- uaddr  out  UADDR_W  current uPC
- ctrl  out  CTRL_W  datapath control field
- stall  out  1  current microword waiting on memory
- instr_done  out  1  macro-instruction boundary this cycle
- uerr  out  1  sticky microstack error

## Operation
- Microword fields, LSB first: ctrl[CTRL_W], target[UADDR_W], cond_sel[FLAG_SEL_W], cond_pol[1], wait[1], seq[3].
- ctrl = uword ctrl field while res is high. It is forced to 0 while res is low.
- Stall: stall = wait & ~mem_ready. While stalled, the uPC, stack and uerr hold and instr_done = 0. ctrl stays driven, because the datapath qualifies its writes with ~stall.
- When not stalled, seq selects the next uPC:
  - 0 NEXT: uPC+1.
  - 1 JUMP: target.
  - 2 DISPATCH: target + opcode, truncated to UADDR_W.
  - 3 CBRANCH: target if flags[cond_sel] == cond_pol, else uPC+1.
  - 4 CALL: push uPC+1, then target.
  - 5 RET: pop to uPC.
  - 6 END: uPC <= 0 and instr_done = 1.
  - 7 reserved, behaves as NEXT.
- Arithmetic: all uPC sums are modulo 2**UADDR_W, so uPC+1 at all-ones wraps to 0.
- Stack overflow (CALL with STACK_DEPTH entries): the push is discarded, the jump to target still happens, and uerr is set.
- Stack underflow (RET on empty stack): uPC <= 0 and uerr is set.
- uerr stays high until reset.
- END does not clear the stack. Microcode is responsible for keeping it balanced.

## Timing
- Reset values: uPC = 0, stack pointer = 0, stack contents = 0, uerr = 0; hence uaddr = 0, ctrl = 0, stall = wait bit of word 0 & ~mem_ready, instr_done = 0.
- Reset assertion takes effect immediately, mid-microinstruction or mid-stall. The first post-reset edge executes word 0.
- One microinstruction per clk when not stalled. The uPC updates on the rising edge, so the ROM sees the new uaddr in the same cycle.
- stall, instr_done and ctrl are combinational from uword, uPC, flags and mem_ready; the datapath samples them at the same edge.
- The flag and opcode values used are those present at the rising edge that executes the CBRANCH or DISPATCH.
- A stall on an END, CBRANCH, CALL or RET word defers that word's entire effect until the first cycle with mem_ready = 1.

## Configuration
- MICROSEQ_STACK_EN defined: return stack, CALL/RET and stack-related uerr are implemented as above.
- MICROSEQ_STACK_EN undefined: no stack storage, CALL behaves as JUMP, RET behaves as END without asserting instr_done, and uerr is tied to 0.

## Test plan
- Reset: hold res = 0, drive word 0 with ctrl = 0x12345 -> ctrl = 0, uaddr = 0. Release res -> ctrl = 0x12345; the next edge applies word 0's seq.
- Dispatch: opcode = 8'h03, word 0 = DISPATCH target 6'h10 -> uaddr = 6'h13 after one edge. Then target 6'h3E with opcode 8'h05 -> uaddr = 6'h03 (wrap).
- Conditional branch: CBRANCH cond_sel = 1, cond_pol = 1, target 6'h20, with flags = 4'b0010 -> uaddr = 6'h20. With flags = 4'b0000 -> uPC+1.
- Stall: a word with wait = 1 and seq = END, mem_ready = 0 for 3 cycles -> uaddr held, stall = 1, instr_done = 0. With mem_ready = 1 -> instr_done pulses for 1 cycle and uaddr = 0 next.
- Stack (STACK_DEPTH = 2, macro defined): CALL at 5 to 8, CALL at 8 to 12, RET, RET -> uaddr sequence 8, 12, 9, 6 with uerr = 0. A third nested CALL -> jump taken and uerr = 1. RET on empty -> uaddr = 0 and uerr = 1.
- Macro undefined: CALL at 5 to 8 then RET -> uaddr 8, then 0, with instr_done = 0 and uerr = 0.
